regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
Parametrised, next-generation general-purpose register file for the pipelined CPU.
- Two combinational read ports and one write port.
- Optional hard-wired zero register and optional write-to-read bypass.
- A pending-write scoreboard, so decode can detect RAW hazards.
- A post-reset clear sweep that zeroes every entry before the file accepts traffic.

Sits between decode (read/issue) and writeback (write).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 reads 0, ignores writes, is never busy
BYPASS, 1, 1 = same-cycle write data/clear visible on read/busy outputs

Ports:
CLOCK  in  1  clock; all state updates on posedge
RESET  in  1  synchronous, active-high reset
A1  in  ADDR_W  read port 1 address
A2  in  ADDR_W  read port 2 address
RD1  out  DATA_W  read port 1 data
RD2  out  DATA_W  read port 2 data
A3  in  ADDR_W  write address
WD3  in  DATA_W  write data
RegWriteW  in  1  write enable (writeback stage)
IssueValid  in  1  mark IssueAddr as pending write
IssueAddr  in  ADDR_W  destination of issued instruction
Busy1  out  1  A1 has a pending write
Busy2  out  1  A2 has a pending write
Ready  out  1  clear sweep finished; file usable

Behaviour:
- Interface decision: one clock (CLOCK), synchronous active-high reset (RESET).
- FSM states: CLEAR, RUN.
- RESET high at a posedge sets:
  - state=CLEAR, sweep ptr=0;
  - all busy bits=0;
  - Ready=0.
  - Memory contents are not reset directly.
- CLEAR:
  - Each posedge with RESET low writes 0 to mem[ptr] and increments ptr.
  - The edge that writes entry DEPTH-1 sets state=RUN and Ready=1.
  - Ready is therefore first high exactly DEPTH cycles after RESET deasserts (32 for defaults).
  - RESET mid-sweep restarts at ptr=0.
  - ptr is ADDR_W bits wide; it wraps to 0 on the final write and is unused afterwards.
- While Ready=0:
  - RegWriteW and IssueValid are ignored;
  - RD1/RD2 = 0;
  - Busy1/Busy2 = 0.
- Write (RUN): at posedge, if RegWriteW and not (ZERO_REG and A3==0), mem[A3]<=WD3. No negedge logic.
- Read (combinational), evaluated per port with addr = A1 or A2:
  - ZERO_REG and addr==0 -> 0.
  - Else, BYPASS and Ready and RegWriteW and A3==addr -> WD3.
  - Else -> mem[addr].
- Scoreboard: busy[DEPTH] bit vector, updated at posedge in RUN.
  - IssueValid sets busy[IssueAddr].
  - RegWriteW clears busy[A3].
  - IssueValid and RegWriteW to the same address in the same cycle: set wins (a new producer is in flight).
  - Issue to an already-busy entry leaves it busy. Only a single outstanding producer per register is tracked; there is no counting.
  - With ZERO_REG, entry 0 is never set busy.
- Busy outputs:
  - BusyN = busy[AN], masked as follows:
    - with BYPASS, forced 0 when RegWriteW and A3==AN that cycle;
    - with ZERO_REG, forced 0 for AN==0.
  - Same-cycle IssueValid is not reflected until the next cycle.
- Reset values: RD1=RD2=0, Busy1=Busy2=0, Ready=0.
- Width rules: no arithmetic beyond the ptr increment. DATA_W values pass through unmodified; no sign handling.

Decomposition:
- Package regfile_pkg:
  - state enum {CLEAR, RUN};
  - DEPTH derivation helper;
  - ZERO_ADDR constant.
- Sub-module regfile_busy_table (scoreboard):
  - parameters ADDR_W, ZERO_REG, BYPASS;
  - inputs: set/clear addresses and enables, two query addresses, Ready gating;
  - outputs: Busy1, Busy2.
- Storage, clear FSM and read muxing stay in the top module.

Test Plan:
- Reset sweep: RESET 1 cycle, then low -> Ready=0 for 31 cycles, high at cycle 32. Reading A1=7 during the sweep returns 0. RegWriteW to A3=7 at cycle 10 is discarded (RD1=0 after Ready).
- Write/read with bypass: Ready; RegWriteW=1, A3=5, WD3=0xDEADBEEF, A1=5 same cycle -> RD1=0xDEADBEEF combinationally. Next cycle with RegWriteW=0 -> still 0xDEADBEEF.
- Zero register: write A3=0, WD3=0x1234 -> RD1 for A1=0 stays 0. IssueValid to 0 -> Busy1 stays 0.
- Scoreboard: IssueValid, IssueAddr=9 -> next cycle Busy2=1 with A2=9. RegWriteW to A3=9 -> Busy2=0 in that same cycle (BYPASS=1) and stays 0.
- Set-wins: IssueValid to 12 and RegWriteW to A3=12 in the same cycle, with busy[12] already 1 -> busy[12]=1 next cycle and mem[12]=WD3.
- Mid-sweep reset: assert RESET at sweep cycle 20 -> ptr restarts at 0; Ready rises 32 cycles after the second release. BYPASS=0 build: same-cycle read of A3 returns the old value.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded register file.
package regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int ZERO_ADDR = 32'sd0;

    function automatic int depth_of(input int addr_w);
        return 32'sd1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback-facing port bundle of the register file.
interface regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] A1;
    logic [ADDR_W-1:0] A2;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic [ADDR_W-1:0] A3;
    logic [DATA_W-1:0] WD3;
    logic              RegWriteW;
    logic              IssueValid;
    logic [ADDR_W-1:0] IssueAddr;
    logic              Busy1;
    logic              Busy2;
    logic              Ready;

    modport master (
        output A1, A2, A3, WD3, RegWriteW, IssueValid, IssueAddr,
        input  RD1, RD2, Busy1, Busy2, Ready
    );

    modport slave (
        input  A1, A2, A3, WD3, RegWriteW, IssueValid, IssueAddr,
        output RD1, RD2, Busy1, Busy2, Ready
    );
endinterface

// File: rtl/regfile_busy_table.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
module regfile_busy_table
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ready,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] q1_addr,
    input  logic [ADDR_W-1:0] q2_addr,
    output logic              busy1,
    output logic              busy2
);
    localparam int DEPTH = depth_of(ADDR_W);

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] busy_nx_s;
    logic [DEPTH-1:0] set_vec_s;
    logic [DEPTH-1:0] clr_vec_s;

    function automatic logic query(
        input logic [DEPTH-1:0]  busy,
        input logic [ADDR_W-1:0] addr,
        input logic              rdy,
        input logic              wr,
        input logic [ADDR_W-1:0] wr_addr
    );
        logic bypass_hit;
        logic zero_hit;
        bypass_hit = BYPASS && wr && (wr_addr == addr);
        zero_hit   = ZERO_REG && (addr == ADDR_W'(ZERO_ADDR));
        return rdy && busy[addr] && !bypass_hit && !zero_hit;
    endfunction

    // Next busy vector; a same-cycle issue overrides the writeback clear.
    always_comb begin
        set_vec_s = {DEPTH{1'b0}};
        clr_vec_s = {DEPTH{1'b0}};
        busy_nx_s = busy_r;
        for (int i = 0; i < DEPTH; i++) begin
            set_vec_s[i] = set_en && (set_addr == ADDR_W'(i))
                           && !(ZERO_REG && (i == ZERO_ADDR));
            clr_vec_s[i] = clr_en && (clr_addr == ADDR_W'(i));
            busy_nx_s[i] = ready ? (set_vec_s[i] | (busy_r[i] & ~clr_vec_s[i])) : busy_r[i];
        end
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            busy_r <= busy_nx_s;
        end
    end

    assign busy1 = query(busy_r, q1_addr, ready, clr_en, clr_addr);
    assign busy2 = query(busy_r, q2_addr, ready, clr_en, clr_addr);

endmodule

// File: rtl/regfile_scoreboard.sv
// 2R/1W register file with post-reset clear sweep, optional zero register,
// optional write bypass and a RAW-hazard scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic     CLOCK,
    input  logic     RESET,
    regfile_if.slave rf
);
    localparam int                DEPTH     = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            state_r;
    state_t            state_nx_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] ptr_nx_s;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              ready_s;
    logic              wr_en_s;

    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              rdy,
        input logic              wr,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data
    );
        logic [DATA_W-1:0] v;
        if (!rdy) begin
            v = {DATA_W{1'b0}};
        end else if (ZERO_REG && (addr == ADDR_W'(ZERO_ADDR))) begin
            v = {DATA_W{1'b0}};
        end else if (BYPASS && wr && (wr_addr == addr)) begin
            v = wr_data;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    assign ready_s = (state_r == RUN);
    assign wr_en_s = ready_s && rf.RegWriteW;

    // Clear-sweep sequencing: step the pointer until the last entry is zeroed.
    always_comb begin
        state_nx_s = state_r;
        ptr_nx_s   = ptr_r;
        case (state_r)
            CLEAR: begin
                ptr_nx_s = ptr_r + ADDR_W'(1);
                if (ptr_r == LAST_ADDR) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = CLEAR;
                end
            end
            RUN: begin
                state_nx_s = RUN;
            end
            default: begin
                state_nx_s = CLEAR;
                ptr_nx_s   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State and sweep pointer registers.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r <= CLEAR;
            ptr_r   <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            ptr_r   <= ptr_nx_s;
        end
    end

    // Storage: sweep zeroes entries in CLEAR, writeback port owns it in RUN.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            if (state_r == CLEAR) begin
                mem_r[ptr_r] <= {DATA_W{1'b0}};
            end else if (rf.RegWriteW && !(ZERO_REG && (rf.A3 == ADDR_W'(ZERO_ADDR)))) begin
                mem_r[rf.A3] <= rf.WD3;
            end
        end
    end

    assign rf.RD1   = read_sel(rf.A1, mem_r[rf.A1], ready_s, wr_en_s, rf.A3, rf.WD3);
    assign rf.RD2   = read_sel(rf.A2, mem_r[rf.A2], ready_s, wr_en_s, rf.A3, rf.WD3);
    assign rf.Ready = ready_s;

    regfile_busy_table #(
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_busy (
        .clk     (CLOCK),
        .rst     (RESET),
        .ready   (ready_s),
        .set_en  (rf.IssueValid),
        .set_addr(rf.IssueAddr),
        .clr_en  (rf.RegWriteW),
        .clr_addr(rf.A3),
        .q1_addr (rf.A1),
        .q2_addr (rf.A2),
        .busy1   (rf.Busy1),
        .busy2   (rf.Busy2)
    );

endmodule
